// File: rtl/xor_alu_pkg.sv
// Shared definitions for the 16-bit XOR datapath: LFSR constants, FSM states
// and the word-wide keystream advance used by both scrambler and descrambler.
package xor_alu_pkg;

    localparam int unsigned WIDTH        = 16;
    localparam logic [15:0] TAPS         = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // One Fibonacci shift: feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & TAPS)};
    endfunction

    // Sixteen shifts unrolled into one combinational cone, one per data word.
    function automatic logic [15:0] lfsr_step16(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr16_keystream.sv
// Keystream generator: holds the LFSR state, loads a seed (zero replaced by the
// default seed so the register never locks up at 0) and advances one word.
module lfsr16_keystream
    import xor_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] keystream_o
);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    // Next LFSR value: load has priority over advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_step16(lfsr_q);
        end
    end

    // LFSR register with synchronous reset to the default seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign keystream_o = lfsr_q;

endmodule

// File: rtl/xor_descrambler.sv
// Additive descrambler: XORs each accepted word with the current keystream and
// presents it through a one-entry registered output stage.
module xor_descrambler
    import xor_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [15:0]      word_count,
    output logic             seeded
);

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [15:0]      word_count_q;
    logic             seeded_q;
    logic [WIDTH-1:0] keystream;
    logic             accept;

    // A seed strobe or reset blocks acceptance so a colliding word is never taken.
    always_comb begin
        in_ready = (state_q == StRun) && (!out_valid_q || out_ready) && !seed_load && !rst;
        accept   = in_valid && in_ready;
    end

    lfsr16_keystream u_keystream (
        .clk         (clk),
        .rst         (rst),
        .load_i      (seed_load),
        .advance_i   (accept),
        .seed_i      (seed_in),
        .keystream_o (keystream)
    );

    // FSM, output register and word counter; drain and accept may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            word_count_q <= '0;
            seeded_q     <= 1'b0;
        end else if (seed_load) begin
            state_q      <= StRun;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
            seeded_q     <= 1'b1;
        end else if (accept) begin
            out_data_q   <= in_data ^ keystream;
            out_valid_q  <= 1'b1;
            word_count_q <= word_count_q + 16'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;
    assign seeded     = seeded_q;

endmodule

// File: doc/xor_descrambler.md
Name: xor_descrambler

Overview:
- Sequential receive-side counterpart to the 16-bit XOR datapath: an additive descrambler that recovers plaintext words by XOR-ing each received 16-bit word with an LFSR keystream.
- Pairs with a matching scrambler on the transmit side that uses the same seed and polynomial.
- Sits between an upstream word source and downstream ALU operand logic.
- Uses valid/ready handshakes on both sides, a registered output, and a seed-load state machine.

Parameters:
- WIDTH, 16, data and LFSR width; only 16 is supported.
- TAPS, 16'hB400, feedback tap mask (bits 15, 13, 12, 10; polynomial x^16+x^14+x^13+x^11+1).
- DEFAULT_SEED, 16'hACE1, substituted whenever a zero seed is loaded.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- seed_load  input  1  one-cycle strobe that loads seed_in into the LFSR.
- seed_in  input  16  seed value.
- in_valid  input  1  upstream word valid.
- in_data  input  16  scrambled word.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  descrambled word valid.
- out_data  output  16  descrambled word.
- out_ready  input  1  downstream accepts out_data.
- word_count  output  16  number of words accepted since the last seed or reset; wraps.
- seeded  output  1  high in RUN.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, lfsr=DEFAULT_SEED.
  - out_valid=0, out_data=0, word_count=0, seeded=0.
  - Reset overrides every other input, including mid-transfer; a pending output word is discarded.
- States:
  - IDLE: in_ready=0.
  - RUN: in_ready = !out_valid || out_ready (one-entry output register, full-throughput pass).
- seed_load (any state):
  - Next state is RUN.
  - lfsr = (seed_in==0) ? DEFAULT_SEED : seed_in.
  - out_valid=0 (pending word dropped), word_count=0.
  - in_ready is forced 0 in any cycle where seed_load=1, so seed_load and in_valid together never accept a word.
- Single-step LFSR function:
  - fb = ^(s & TAPS).
  - step(s) = {s[14:0], fb}.
- Accept (state RUN, in_valid && in_ready, no seed_load):
  - out_data <= in_data ^ lfsr; out_valid <= 1.
  - lfsr <= 16 applications of step(lfsr), implemented as one combinational unrolled function with no multi-cycle stepping.
  - word_count <= word_count+1 (mod 2^16; 16'hFFFF wraps to 0).
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid <= 0.
  - Simultaneous drain and accept: out_valid stays 1, and out_data takes the new word in that same edge.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Latency: exactly 1 cycle from accept edge to out_valid.
- Keystream:
  - Depends only on the seed and the number of accepted words, never on stall cycles.
  - The LFSR never reaches 0, because the zero-seed substitution keeps it off the lock-up state.

Decomposition:
- Shared package xor_alu_pkg: WIDTH, TAPS, DEFAULT_SEED, a state enum (IDLE, RUN), and an lfsr_step16 function (16 unrolled steps) reused by the future scrambler.
- One natural sub-module, lfsr16_keystream: holds the LFSR register and has load/advance/seed inputs and a keystream output. The top level holds the FSM, output register and counter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=1 with no seed → in_ready=0, out_valid=0, word_count=0, seeded=0 for 10 cycles.
- First word: seed_load with seed_in=16'hACE1, then in_data=16'h0000 → out_data=16'hACE1 one cycle later. Reseed and send 16'hFFFF → out_data=16'h531E. word_count=1 after each.
- Zero seed: seed_in=16'h0000 then in_data=16'h1234 → out_data=16'h1234^16'hACE1=16'hBED5.
- Backpressure: hold out_ready=0 across 3 offered words → first word held stable, in_ready=0, only 1 accepted. Release out_ready → remaining words emerge in order with no bubbles, and values match a software model that does not depend on stall cycles.
- Round trip: a reference scrambler model with seed 16'h1D2C scrambles 300 random words → descrambled stream equals the original. word_count=300, and wrap is verified separately by preloading 65535 accepts.
- Seed collision and mid-reset: seed_load and in_valid high together → word not accepted and word_count=0. rst asserted while out_valid=1 → out_valid=0 and state=IDLE on the next edge.
